// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_pkg
// Purpose  : Shared defaults and types for the PWM duty scheduler.
//            Holds the default counter/duty width, the default channel count,
//            the channel-index and duty types, and the mode encoding.
// Revision : 1.0 - initial release
// ============================================================================
package pwm_pkg;

  localparam int CBITS_DEF = 14;
  localparam int NCH_DEF   = 4;
  localparam int CHB_DEF   = $clog2(NCH_DEF);

  typedef logic [CHB_DEF-1:0]   ch_idx_t;
  typedef logic [CBITS_DEF-1:0] duty_t;

  typedef enum logic [0:0] {
    DISABLED = 1'b0,
    RUN      = 1'b1
  } mode_e;

endpackage : pwm_pkg
`default_nettype wire

// File: rtl/pwm_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pwm_rr_arbiter
// Purpose  : Purely combinational round-robin arbiter. Grants the first
//            asserted request at or after the pointer (searching modulo
//            NREQ) and returns the pointer value to store for the next cycle.
// Ports    : valid    - per-requester request vector
//            ptr      - current round-robin pointer
//            grant    - one-hot grant, or zero when nothing is requested
//            ptr_next - pointer after this cycle (grant+1, or unchanged)
// Revision : 1.0 - initial release
// ============================================================================
module pwm_rr_arbiter #(
  parameter  int NREQ = 2,
  localparam int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   ptr_next
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    grant    = '0;
    ptr_next = ptr;
    found    = 1'b0;
    idx      = '0;
    for (int off = 0; off < NREQ; off++) begin
      idx = PW'((int'(ptr) + off) % NREQ);
      if (!found && valid[idx]) begin
        found     = 1'b1;
        grant[idx] = 1'b1;
        // Every grant is a transfer (ready only follows valid), so the
        // pointer always moves past the winner.
        ptr_next  = (idx == PW'(NREQ - 1)) ? '0 : idx + PW'(1);
      end
    end
  end

endmodule : pwm_rr_arbiter
`default_nettype wire

// File: rtl/pwm_duty_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : pwm_duty_scheduler
// Purpose  : Shared-timebase PWM controller. One free-running period counter
//            drives NCH compare outputs. Requesters submit duty updates via
//            valid/ready; a round-robin arbiter accepts one per cycle into a
//            per-channel shadow register, which is committed to the active
//            duty at the period boundary (or immediately while disabled).
// Ports    : clk, rst_n     - clock, asynchronous active-low reset
//            enable         - 1 runs the counter, 0 holds it at 0
//            req_valid/ch/duty - packed per-requester update requests
//            req_ready      - one-hot combinational grant
//            pwm_out        - registered PWM outputs
//            period_start   - registered pulse for count 0
//            pending        - shadow duty awaiting commit, per channel
//            cnt            - current counter value
// Revision : 1.0 - initial release
// ============================================================================
module pwm_duty_scheduler
  import pwm_pkg::*;
#(
  parameter int CBITS = CBITS_DEF,
  parameter int NCH   = NCH_DEF,
  parameter int NREQ  = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [NREQ*$clog2(NCH)-1:0]   req_ch,
  input  logic [NREQ*CBITS-1:0]         req_duty,
  output logic [NREQ-1:0]               req_ready,
  output logic [NCH-1:0]                pwm_out,
  output logic                          period_start,
  output logic [NCH-1:0]                pending,
  output logic [CBITS-1:0]              cnt
);

  localparam int               CHB     = $clog2(NCH);
  localparam int               PW      = $clog2(NREQ);
  localparam logic [CBITS-1:0] CNT_MAX = '1;

  mode_e             mode_q, mode_d;
  logic [CBITS-1:0]  cnt_q, cnt_d;
  logic [NCH-1:0]    pwm_q, pwm_d;
  logic [NCH-1:0]    pending_q, pending_d;
  logic              ps_q, ps_d;
  logic [CBITS-1:0]  active_q [NCH];
  logic [CBITS-1:0]  active_d [NCH];
  logic [CBITS-1:0]  shadow_q [NCH];
  logic [CBITS-1:0]  shadow_d [NCH];
  logic [PW-1:0]     ptr_q, ptr_d;

  logic [NREQ-1:0]   grant;
  logic              xfer;
  logic [CHB-1:0]    sel_ch;
  logic [CBITS-1:0]  sel_duty;
  logic              commit;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  pwm_rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .valid    (req_valid),
    .ptr      (ptr_q),
    .grant    (grant),
    .ptr_next (ptr_d)
  );

  assign req_ready = grant;

  always_comb begin
    xfer     = |grant;
    sel_ch   = '0;
    sel_duty = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) begin
        sel_ch   = req_ch[k*CHB +: CHB];
        sel_duty = req_duty[k*CBITS +: CBITS];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Mode FSM: the next mode already governs this edge, so a change of enable
  // takes effect on the same edge it is sampled.
  // --------------------------------------------------------------------------
  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      DISABLED: if (enable)  mode_d = RUN;
      RUN:      if (!enable) mode_d = DISABLED;
      default:  mode_d = DISABLED;
    endcase
  end

  // --------------------------------------------------------------------------
  // Counter, compare outputs and commit strobe
  // --------------------------------------------------------------------------
  always_comb begin
    cnt_d  = '0;
    pwm_d  = '0;
    ps_d   = 1'b0;
    // While disabled, pending duties commit on every edge.
    commit = 1'b1;
    if (mode_d == RUN) begin
      cnt_d  = cnt_q + CBITS'(1);
      ps_d   = (cnt_q == '0);
      commit = (cnt_q == CNT_MAX);
      for (int i = 0; i < NCH; i++) begin
        pwm_d[i] = (cnt_q < active_q[i]);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Shadow / active registers. Commit reads the pre-edge shadow; a transfer on
  // the same edge is applied afterwards so it stays pending for next period.
  // --------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      active_d[i]  = active_q[i];
      shadow_d[i]  = shadow_q[i];
      pending_d[i] = pending_q[i];
      if (commit && pending_q[i]) begin
        active_d[i]  = shadow_q[i];
        pending_d[i] = 1'b0;
      end
      if (xfer && (sel_ch == CHB'(i))) begin
        shadow_d[i]  = sel_duty;
        pending_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= DISABLED;
      cnt_q     <= '0;
      pwm_q     <= '0;
      ps_q      <= 1'b0;
      pending_q <= '0;
      ptr_q     <= '0;
      for (int i = 0; i < NCH; i++) begin
        active_q[i] <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      pwm_q     <= pwm_d;
      ps_q      <= ps_d;
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      for (int i = 0; i < NCH; i++) begin
        active_q[i] <= active_d[i];
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = ps_q;
  assign pending      = pending_q;
  assign cnt          = cnt_q;

endmodule : pwm_duty_scheduler
`default_nettype wire

// File: tb/tb_pwm_duty_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_duty_scheduler
// Purpose  : Self-checking bench for pwm_duty_scheduler (CBITS=4, NCH=4,
//            NREQ=2). A period-level behavioural model tracks the expected
//            outputs; directed scenarios pin the model with literal values
//            and a randomized phase exercises arbitration and enable toggles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_duty_scheduler;

  localparam int CB  = 4;
  localparam int NC  = 4;
  localparam int NR  = 2;
  localparam int CHB = 2;
  localparam int PER = 1 << CB;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic              enable    = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*CHB-1:0] req_ch    = '0;
  logic [NR*CB-1:0]  req_duty  = '0;
  logic [NR-1:0]     req_ready;
  logic [NC-1:0]     pwm_out;
  logic              period_start;
  logic [NC-1:0]     pending;
  logic [CB-1:0]     cnt;

  pwm_duty_scheduler #(
    .CBITS (CB),
    .NCH   (NC),
    .NREQ  (NR)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .req_valid    (req_valid),
    .req_ch       (req_ch),
    .req_duty     (req_duty),
    .req_ready    (req_ready),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .pending      (pending),
    .cnt          (cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  int m_cnt, m_ptr, m_ps, last_grant;
  int m_active [NC];
  int m_shadow [NC];
  bit m_pend   [NC];
  bit m_pwm    [NC];
  bit chk_en = 1'b0;
  int nchk = 0;
  int nerr = 0;

  task automatic check(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int arb(input int ptr, input logic [NR-1:0] v);
    for (int o = 0; o < NR; o++) begin
      int i;
      i = (ptr + o) % NR;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_ptr = 0; m_ps = 0; last_grant = -1;
    for (int i = 0; i < NC; i++) begin
      m_active[i] = 0; m_shadow[i] = 0; m_pend[i] = 0; m_pwm[i] = 0;
    end
  endtask

  // One rising edge of the specified behaviour.
  task automatic model_step();
    int g, c;
    bit commit;
    g = arb(m_ptr, req_valid);
    if (enable) begin
      for (int i = 0; i < NC; i++) m_pwm[i] = (m_cnt < m_active[i]);
      m_ps   = (m_cnt == 0);
      commit = (m_cnt == PER - 1);
      m_cnt  = (m_cnt + 1) % PER;
    end else begin
      for (int i = 0; i < NC; i++) m_pwm[i] = 0;
      m_ps = 0; m_cnt = 0; commit = 1;
    end
    if (commit)
      for (int i = 0; i < NC; i++)
        if (m_pend[i]) begin m_active[i] = m_shadow[i]; m_pend[i] = 0; end
    if (g >= 0) begin
      c = int'(req_ch[g*CHB +: CHB]);
      m_shadow[c] = int'(req_duty[g*CB +: CB]);
      m_pend[c]   = 1;
      m_ptr       = (g + 1) % NR;
    end
    last_grant = g;
  endtask

  // Compare process: registered outputs against the model every cycle.
  always @(negedge clk) begin
    logic [NC-1:0] epw, epd;
    if (chk_en) begin
      for (int i = 0; i < NC; i++) begin
        epw[i] = m_pwm[i];
        epd[i] = m_pend[i];
      end
      check("cnt", int'(cnt), m_cnt);
      check("pwm_out", int'(pwm_out), int'(epw));
      check("period_start", int'(period_start), m_ps);
      check("pending", int'(pending), int'(epd));
    end
  end

  // Called just after a falling edge with inputs already driven.
  task automatic tick();
    int g;
    logic [NR-1:0] er;
    #1;
    g  = arb(m_ptr, req_valid);
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    check("req_ready", int'(req_ready), int'(er));
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_req(input int k, input bit v, input int ch, input int d);
    req_valid[k]             = v;
    req_ch[k*CHB +: CHB]     = ch[CHB-1:0];
    req_duty[k*CB +: CB]     = d[CB-1:0];
  endtask

  task automatic wait_cnt(input int target);
    for (int n = 0; n < 2*PER + 8; n++) begin
      if (int'(cnt) == target) break;
      tick();
    end
    check("wait_cnt_bound", int'(cnt), target);
  endtask

  // Observe one full period starting from an observed cnt of 0.
  task automatic measure(input int ch, output int hi, output int psn, output int lastbit);
    hi = 0; psn = 0; lastbit = 0;
    for (int n = 0; n < PER; n++) begin
      tick();
      hi      += int'(pwm_out[ch]);
      psn     += int'(period_start);
      lastbit  = int'(pwm_out[ch]);
    end
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_cnt", int'(cnt), 0);
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_ps", int'(period_start), 0);
    check("rst_pending", int'(pending), 0);
    req_valid = '0;
    enable    = 1'b0;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  initial begin
    int hi, psn, lb;
    logic [NR-1:0] gseq [4];

    model_reset();
    repeat (3) @(negedge clk);
    check("init_cnt", int'(cnt), 0);
    check("init_pending", int'(pending), 0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Scenario 1: basic write, commit at period end, 5-cycle pulse.
    enable = 1'b1;
    tick();
    check("t1_first_cnt", int'(cnt), 1);
    check("t1_first_ps", int'(period_start), 1);
    wait_cnt(3);
    set_req(0, 1, 0, 5);
    tick();
    set_req(0, 0, 0, 0);
    check("t1_pending_set", int'(pending[0]), 1);
    wait_cnt(15);
    check("t1_pending_hold", int'(pending[0]), 1);
    tick();
    check("t1_pending_clr", int'(pending[0]), 0);
    measure(0, hi, psn, lb);
    check("t1_high_cycles", hi, 5);
    check("t1_ps_per_period", psn, 1);

    // Scenario 2: both requesters valid every cycle, alternate grants.
    do_reset();
    enable = 1'b1;
    set_req(0, 1, 1, 4);
    set_req(1, 1, 2, 11);
    for (int j = 0; j < 4; j++) begin
      #1;
      gseq[j] = req_ready;
      tick();
    end
    check("t2_grant0", int'(gseq[0]), 1);
    check("t2_grant1", int'(gseq[1]), 2);
    check("t2_grant2", int'(gseq[2]), 1);
    check("t2_grant3", int'(gseq[3]), 2);
    req_valid = '0;

    // Scenario 3: transfer on the commit edge to a channel already pending.
    wait_cnt(5);
    set_req(0, 1, 1, 3);
    tick();
    set_req(0, 0, 0, 0);
    wait_cnt(15);
    set_req(0, 1, 1, 9);
    tick();
    set_req(0, 0, 0, 0);
    check("t3_pending_after_commit", int'(pending[1]), 1);
    measure(1, hi, psn, lb);
    check("t3_first_period", hi, 3);
    check("t3_pending_clr", int'(pending[1]), 0);
    measure(1, hi, psn, lb);
    check("t3_second_period", hi, 9);

    // Scenario 4: duty extremes.
    wait_cnt(2);
    set_req(0, 1, 2, 0);
    tick();
    set_req(0, 1, 3, 15);
    tick();
    set_req(0, 0, 0, 0);
    wait_cnt(15);
    tick();
    measure(2, hi, psn, lb);
    check("t4_duty0", hi, 0);
    measure(3, hi, psn, lb);
    check("t4_duty15", hi, 15);
    check("t4_duty15_last_low", lb, 0);

    // Scenario 5: enable dropped mid-period with a pending write.
    wait_cnt(2);
    set_req(0, 1, 0, 7);
    tick();
    set_req(0, 0, 0, 0);
    wait_cnt(7);
    enable = 1'b0;
    tick();
    check("t5_cnt_zero", int'(cnt), 0);
    check("t5_pwm_zero", int'(pwm_out), 0);
    check("t5_pending_commit", int'(pending[0]), 0);
    repeat (3) tick();
    enable = 1'b1;
    measure(0, hi, psn, lb);
    check("t5_reenable_duty", hi, 7);
    check("t5_reenable_ps", psn, 1);

    // Scenario 6: async reset mid-period with pending writes.
    wait_cnt(9);
    set_req(0, 1, 1, 6);
    tick();
    set_req(0, 0, 0, 0);
    check("t6_pending_before", int'(pending[1]), 1);
    do_reset();
    enable = 1'b1;
    set_req(0, 1, 2, 1);
    set_req(1, 1, 3, 2);
    #1;
    check("t6_ptr_zero_grant", int'(req_ready), 1);
    tick();
    req_valid = '0;

    // Randomized phase.
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < NR; k++) begin
        if (req_valid[k]) begin
          if (last_grant == k) begin
            if ($urandom_range(0, 1) == 1)
              set_req(k, 1, int'($urandom_range(0, NC-1)), int'($urandom_range(0, PER-1)));
            else
              set_req(k, 0, 0, 0);
          end else if ($urandom_range(0, 7) == 0) begin
            set_req(k, 0, 0, 0);
          end
        end else if ($urandom_range(0, 1) == 1) begin
          set_req(k, 1, int'($urandom_range(0, NC-1)), int'($urandom_range(0, PER-1)));
        end
      end
      if ($urandom_range(0, 99) == 0) enable = ~enable;
      tick();
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule : tb_pwm_duty_scheduler
`default_nettype wire
